// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rtc_bus_sequencer
// Purpose : Turns single-cycle read/write requests into timed multiplexed
//           address/data bus cycles on an external RTC chip. Each cycle walks
//           through ADDR, AHOLD, SETUP, STROBE, DHOLD and RECOV, each lasting
//           T_PH clocks. Read data is returned with a one-cycle valid pulse.
// Revision: 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
  parameter int T_PH = 10,
  parameter int AW   = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_wr,
  input  logic          start_rd,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  input  logic [7:0]    ad_in,
  output logic [7:0]    ad_out,
  output logic          ad_oe,
  output logic          cs_n,
  output logic          ale,
  output logic          rd_n,
  output logic          wr_n,
  output logic [7:0]    rdata,
  output logic          rdata_valid,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_AHOLD  = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_DHOLD  = 3'd5;
  localparam logic [2:0] S_RECOV  = 3'd6;

  // Terminal count of the per-phase counter.
  localparam logic [7:0] LAST = 8'(T_PH - 1);

  logic [2:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       op_wr, op_wr_nxt;
  logic [7:0] addr_l, addr_l_nxt;
  logic [7:0] wdata_l, wdata_l_nxt;
  logic [7:0] rdata_nxt;
  logic       rdata_valid_nxt;
  logic       done_nxt;
  logic       phase_end;

  logic [7:0] ad_out_nxt;
  logic       ad_oe_nxt;
  logic       cs_n_nxt;
  logic       ale_nxt;
  logic       rd_n_nxt;
  logic       wr_n_nxt;
  logic       busy_nxt;

  assign phase_end = (cnt == LAST);

  // Next-state, phase counter, request latching and read capture.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    op_wr_nxt       = op_wr;
    addr_l_nxt      = addr_l;
    wdata_l_nxt     = wdata_l;
    rdata_nxt       = rdata;
    rdata_valid_nxt = 1'b0;
    done_nxt        = 1'b0;
    if (state == S_IDLE) begin
      cnt_nxt = 8'd0;
      // Write wins when both requests arrive together.
      if (start_wr || start_rd) begin
        state_nxt   = S_ADDR;
        op_wr_nxt   = start_wr;
        addr_l_nxt  = 8'(addr);
        wdata_l_nxt = wdata;
      end
    end else if (phase_end) begin
      cnt_nxt = 8'd0;
      case (state)
        S_ADDR:   state_nxt = S_AHOLD;
        S_AHOLD:  state_nxt = S_SETUP;
        S_SETUP:  state_nxt = S_STROBE;
        S_STROBE: begin
          state_nxt = S_DHOLD;
          // Capture while rd_n is still low, at the end of the strobe.
          if (!op_wr) begin
            rdata_nxt       = ad_in;
            rdata_valid_nxt = 1'b1;
          end
        end
        S_DHOLD:  state_nxt = S_RECOV;
        S_RECOV: begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
        default:  state_nxt = S_IDLE;
      endcase
    end else begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  // Bus pin values for the state being entered, so the pins are registered.
  always_comb begin
    ad_out_nxt = 8'd0;
    ad_oe_nxt  = 1'b0;
    cs_n_nxt   = 1'b1;
    ale_nxt    = 1'b0;
    rd_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    busy_nxt   = 1'b1;
    case (state_nxt)
      S_ADDR: begin
        cs_n_nxt   = 1'b0;
        ale_nxt    = 1'b1;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_l_nxt;
      end
      S_AHOLD: begin
        cs_n_nxt   = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_l_nxt;
      end
      S_SETUP, S_DHOLD: begin
        cs_n_nxt = 1'b0;
        if (op_wr_nxt) begin
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = wdata_l_nxt;
        end
      end
      S_STROBE: begin
        cs_n_nxt = 1'b0;
        if (op_wr_nxt) begin
          wr_n_nxt   = 1'b0;
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = wdata_l_nxt;
        end else begin
          rd_n_nxt = 1'b0;
        end
      end
      S_RECOV: begin
        busy_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State registers and registered outputs; reset aborts any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      op_wr       <= 1'b0;
      addr_l      <= 8'd0;
      wdata_l     <= 8'd0;
      rdata       <= 8'd0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      ad_out      <= 8'd0;
      ad_oe       <= 1'b0;
      cs_n        <= 1'b1;
      ale         <= 1'b0;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_wr       <= op_wr_nxt;
      addr_l      <= addr_l_nxt;
      wdata_l     <= wdata_l_nxt;
      rdata       <= rdata_nxt;
      rdata_valid <= rdata_valid_nxt;
      done        <= done_nxt;
      ad_out      <= ad_out_nxt;
      ad_oe       <= ad_oe_nxt;
      cs_n        <= cs_n_nxt;
      ale         <= ale_nxt;
      rd_n        <= rd_n_nxt;
      wr_n        <= wr_n_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
`default_nettype wire
